// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, frame length
// codes and the decode from length code to frame size.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LEN_8  = 2'b00,
        LEN_16 = 2'b01,
        LEN_24 = 2'b10,
        LEN_32 = 2'b11
    } len_t;

    // Number of bits in a frame: 8 * (code + 1).
    function automatic logic [5:0] frame_bits(input len_t len);
        return {1'b0, len, 3'b000} + 6'd8;
    endfunction

    // Index of the first (most significant) transmitted bit: N - 1.
    function automatic logic [4:0] msb_index(input len_t len);
        return {len, 3'b111};
    endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// Pin and host-side signal bundle of the SPI slave. The slave modport is the
// design's view, the master modport is the view of whatever drives it.
interface spi_slave_sync_if;

    logic        SCLK;
    logic        CS;
    logic        MOSI;
    logic        MISO;
    logic        miso_oe;
    logic        CPOL;
    logic        CPHA;
    logic        daisy_chain;
    logic        default_val;
    logic [1:0]  transaction_length;
    logic [31:0] tx_data;
    logic        tx_load;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;
    logic        tx_underrun;

    modport slave (
        input  SCLK, CS, MOSI, CPOL, CPHA, daisy_chain, default_val,
               transaction_length, tx_data, tx_load,
        output MISO, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err,
               tx_underrun
    );

    modport master (
        output SCLK, CS, MOSI, CPOL, CPHA, daisy_chain, default_val,
               transaction_length, tx_data, tx_load,
        input  MISO, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err,
               tx_underrun
    );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input. rst_val is tied to a
// constant at each instance so the chain resets to the pin's idle level.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] pipe;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments keep every stage sampling the
        // previous stage's old value, which is what makes this a chain.
        if (!rst) begin
            pipe <= {STAGES{rst_val}};
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave clocked entirely by clk. SCLK, CS and MOSI are synchronized and
// edge-detected; frames of 8/16/24/32 bits in any CPOL/CPHA mode.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    spi_slave_sync_if.slave bus
);
    import spi_pkg::*;

    logic sclk_s, cs_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .rst_val(1'b0), .d(bus.SCLK), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .rst_val(1'b1), .d(bus.CS), .q(cs_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .rst_val(1'b0), .d(bus.MOSI), .q(mosi_s));

    state_t            state, state_nxt;
    logic [SYNC_STAGES-1:0] settle;
    logic              settled;
    logic              cs_prev, k_prev, k;
    logic              cs_fall, sample_edge, shift_edge;
    logic              frame_done, frame_abort;
    logic              cpol_r, cpha_r, first_shift;
    len_t              len_r;
    logic [5:0]        bit_cnt;
    logic [31:0]       tx_shift;
    logic [30:0]       rx_shift;   // final bit goes straight into rx_data
    logic [31:0]       staging;
    logic              tx_ready_r;
    logic [31:0]       rx_data_r;
    logic              rx_valid_r, frame_err_r, tx_underrun_r;

    // The sync chains hold their reset values for SYNC_STAGES cycles after
    // release, so CS edges are ignored until real pin values have arrived.
    // A CS already low at release therefore never looks like a falling edge.
    assign settled     = settle[SYNC_STAGES-1];
    assign cs_fall     = settled && cs_prev && !cs_s;
    assign k           = sclk_s ^ cpol_r ^ cpha_r;
    assign sample_edge = (state == ST_ACTIVE) && k && !k_prev;
    assign shift_edge  = (state == ST_ACTIVE) && !k && k_prev;

    // Track settle status and previous CS / k levels for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle  <= '0;
            cs_prev <= 1'b0;
            k_prev  <= 1'b0;
        end else begin
            settle  <= {settle[SYNC_STAGES-2:0], 1'b1};
            cs_prev <= settled ? cs_s : 1'b0;
            // At LOAD the mode is latched this very edge, so seed k_prev
            // from the incoming mode inputs rather than the old latches.
            k_prev  <= (state == ST_LOAD) ? (sclk_s ^ bus.CPOL ^ bus.CPHA) : k;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // FSM next-state and frame-completion decode.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves one unassigned and no latch is inferred.
        state_nxt   = state;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        unique case (state)
            ST_IDLE:   if (cs_fall) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                // Level check on CS also covers a rise that lands on LOAD.
                if (cs_s) begin
                    state_nxt   = ST_IDLE;
                    frame_abort = 1'b1;
                end else if (sample_edge && bit_cnt == 6'd1) begin
                    state_nxt  = ST_DONE;
                    frame_done = 1'b1;
                end
            end
            ST_DONE:   if (cs_s) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Frame datapath: mode latch, bit counter, shift registers, rx result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpol_r        <= 1'b0;
            cpha_r        <= 1'b0;
            len_r         <= LEN_8;
            first_shift   <= 1'b0;
            bit_cnt       <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            rx_data_r     <= '0;
            rx_valid_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            rx_valid_r    <= frame_done;
            frame_err_r   <= frame_abort;
            tx_underrun_r <= 1'b0;
            if (state == ST_LOAD) begin
                cpol_r        <= bus.CPOL;
                cpha_r        <= bus.CPHA;
                len_r         <= len_t'(bus.transaction_length);
                bit_cnt       <= frame_bits(len_t'(bus.transaction_length));
                tx_shift      <= staging;
                rx_shift      <= '0;
                first_shift   <= bus.CPHA;
                // Staging still marked ready means nobody refreshed it.
                tx_underrun_r <= tx_ready_r;
            end else if (sample_edge) begin
                rx_shift <= {rx_shift[29:0], mosi_s};
                bit_cnt  <= bit_cnt - 6'd1;
            end else if (shift_edge) begin
                // In CPHA=1 the leading edge before the first sample only
                // announces the first bit, which is already on MISO.
                if (first_shift) first_shift <= 1'b0;
                else             tx_shift    <= {tx_shift[30:0], bus.default_val};
            end
            if (frame_done) rx_data_r <= {rx_shift, mosi_s};
        end
    end

    // Transmit staging register and its ready/load handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            staging    <= '0;
            tx_ready_r <= 1'b1;
        end else if (state == ST_LOAD) begin
            // LOAD takes the old word; a same-cycle load refills the slot.
            if (bus.tx_load) begin
                staging    <= bus.tx_data;
                tx_ready_r <= 1'b0;
            end else begin
                tx_ready_r <= 1'b1;
            end
        end else if (bus.tx_load && tx_ready_r) begin
            staging    <= bus.tx_data;
            tx_ready_r <= 1'b0;
        end
    end

    // MISO pad drive: bypass or fill bit while deselected, data in frame.
    always_comb begin
        bus.miso_oe = 1'b1;
        bus.MISO    = bus.default_val;
        if (cs_s) begin
            bus.miso_oe = bus.daisy_chain;
            bus.MISO    = bus.daisy_chain ? bus.MOSI : bus.default_val;
        end else if (state != ST_DONE) begin
            bus.MISO = tx_shift[msb_index(len_r)];
        end
    end

    assign bus.busy        = (state != ST_IDLE);
    assign bus.tx_ready    = tx_ready_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.tx_underrun = tx_underrun_r;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Self-checking bench for spi_slave_sync: a behavioural SPI master plus a
// transaction-level model (staging word, expected rx queue, pulse counts).
`timescale 1ns/1ps
module tb_spi_slave_sync;

    localparam int SYNC = 2;
    localparam int HALF = 8;   // clk cycles per SCLK half period

    logic clk = 1'b0;
    logic rst = 1'b0;

    spi_slave_sync_if bus();

    spi_slave_sync #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state.
    logic [31:0] staging_m = '0;
    bit          fresh_m   = 1'b0;
    logic [31:0] rx_q[$];
    logic [31:0] rx_last_m = '0;
    int          err_pend  = 0;
    int          urun_pend = 0;
    int          cs_hi_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] low_bits(input logic [31:0] w, input int nb);
        logic [63:0] m;
        m = (64'd1 << nb) - 64'd1;
        return w & m[31:0];
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_model();
        staging_m = '0;
        fresh_m   = 1'b0;
        rx_q.delete();
        rx_last_m = '0;
        err_pend  = 0;
        urun_pend = 0;
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            cs_hi_cnt = 0;
        end else begin
            if (bus.rx_valid) begin
                check("rx_valid_expected", {31'b0, bus.rx_valid}, {31'b0, rx_q.size() != 0});
                if (rx_q.size() != 0) begin
                    rx_last_m = rx_q.pop_front();
                    check("rx_data_on_valid", bus.rx_data, rx_last_m);
                end
            end else begin
                check("rx_data_hold", bus.rx_data, rx_last_m);
            end
            if (bus.frame_err) begin
                check("frame_err_expected", {31'b0, bus.frame_err}, {31'b0, err_pend > 0});
                if (err_pend > 0) err_pend--;
            end
            if (bus.tx_underrun) begin
                check("tx_underrun_expected", {31'b0, bus.tx_underrun}, {31'b0, urun_pend > 0});
                if (urun_pend > 0) urun_pend--;
            end
            cs_hi_cnt = bus.CS ? cs_hi_cnt + 1 : 0;
            if (cs_hi_cnt > SYNC + 3) begin
                check("idle_miso_oe", bus.miso_oe, bus.daisy_chain);
                check("idle_miso", bus.MISO, bus.daisy_chain ? bus.MOSI : bus.default_val);
                check("idle_busy", bus.busy, 0);
            end
        end
    end

    // Offer a word on the staging handshake; ignored by the model if full.
    task automatic load_word(input logic [31:0] w);
        @(negedge clk);
        check("tx_ready_before_load", bus.tx_ready, !fresh_m);
        bus.tx_data = w;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
        if (!fresh_m) begin
            staging_m = w;
            fresh_m   = 1'b1;
        end
        check("tx_ready_after_load", bus.tx_ready, 0);
    endtask

    // SPI master. Runs stop_at bits (or the whole frame if stop_at >= N),
    // then either raises CS or, with use_rst, asserts reset mid-frame.
    task automatic spi_frame(input bit cpol, input bit cpha, input logic [1:0] len,
                             input logic [31:0] mosi_w, input int stop_at,
                             input bit use_rst, output logic [31:0] miso_w);
        int          nb;
        bit          complete;
        logic [31:0] exp_tx;
        nb       = 8 * (int'(len) + 1);
        complete = (stop_at >= nb);
        exp_tx   = staging_m;
        if (!fresh_m) urun_pend++;
        fresh_m = 1'b0;
        if (complete)      rx_q.push_back(low_bits(mosi_w, nb));
        else if (!use_rst) err_pend++;

        bus.CPOL = cpol;
        bus.CPHA = cpha;
        bus.transaction_length = len;
        bus.SCLK = cpol;
        bus.MOSI = mosi_w[nb-1];
        wait_clks(HALF);
        bus.CS = 1'b0;
        wait_clks(HALF);
        miso_w = '0;
        for (int i = 0; i < nb; i++) begin
            if (i == stop_at) break;
            if (!cpha) begin
                miso_w = {miso_w[30:0], bus.MISO};
                bus.SCLK = ~cpol;
                wait_clks(HALF);
                if (i == 0) begin
                    // Mode inputs wiggled mid-frame must not matter.
                    bus.CPOL = 1'($urandom);
                    bus.CPHA = 1'($urandom);
                    bus.transaction_length = 2'($urandom);
                end
                bus.SCLK = cpol;
                if (i + 1 < nb) bus.MOSI = mosi_w[nb-2-i];
                wait_clks(HALF);
            end else begin
                bus.SCLK = ~cpol;
                bus.MOSI = mosi_w[nb-1-i];
                wait_clks(HALF);
                if (i == 0) begin
                    bus.CPOL = 1'($urandom);
                    bus.CPHA = 1'($urandom);
                    bus.transaction_length = 2'($urandom);
                end
                miso_w = {miso_w[30:0], bus.MISO};
                bus.SCLK = cpol;
                wait_clks(HALF);
            end
        end
        if (use_rst) begin
            rst = 1'b0;
            reset_model();
            #1;
            check("rst_rx_valid", bus.rx_valid, 0);
            check("rst_frame_err", bus.frame_err, 0);
            check("rst_tx_underrun", bus.tx_underrun, 0);
            check("rst_tx_ready", bus.tx_ready, 1);
            check("rst_busy", bus.busy, 0);
            check("rst_rx_data", bus.rx_data, 0);
            check("rst_miso_oe", bus.miso_oe, bus.daisy_chain);
            return;
        end
        if (complete) begin
            check("done_miso_fill", bus.MISO, bus.default_val);
            check("done_miso_oe", bus.miso_oe, 1);
            check("done_busy", bus.busy, 1);
            check("master_rx_word", miso_w, low_bits(exp_tx, nb));
        end
        bus.CS = 1'b1;
        wait_clks(2 * HALF);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m, m2;
        logic [1:0]  r_len;
        bit          r_cpol, r_cpha;
        int          r_stop, r_nb;

        bus.SCLK = 1'b0;
        bus.CS = 1'b1;
        bus.MOSI = 1'b0;
        bus.CPOL = 1'b0;
        bus.CPHA = 1'b0;
        bus.daisy_chain = 1'b0;
        bus.default_val = 1'b0;
        bus.transaction_length = 2'b00;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;

        // Reset state.
        wait_clks(4);
        check("reset_rx_data", bus.rx_data, 0);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_tx_ready", bus.tx_ready, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_tx_underrun", bus.tx_underrun, 0);
        check("reset_miso_oe", bus.miso_oe, 0);
        rst = 1'b1;
        wait_clks(10);

        // Mode 0, 8 bits.
        load_word(32'h000000A5);
        spi_frame(1'b0, 1'b0, 2'b00, 32'h0000003C, 99, 1'b0, m);
        check("mode0_master_word", m, 32'h000000A5);
        check("mode0_rx_data", bus.rx_data, 32'h0000003C);

        // Mode 3, 32 bits.
        load_word(32'hDEADBEEF);
        spi_frame(1'b1, 1'b1, 2'b11, 32'h12345678, 99, 1'b0, m);
        check("mode3_master_word", m, 32'hDEADBEEF);
        check("mode3_rx_data", bus.rx_data, 32'h12345678);

        // Abort after 5 of 16 bits (no load: underrun also expected).
        spi_frame(1'b0, 1'b0, 2'b01, 32'h0000AAAA, 5, 1'b0, m);
        check("abort_err_seen", err_pend, 0);
        check("abort_rx_data_kept", bus.rx_data, 32'h12345678);

        // Two frames, one load: the word is resent with an underrun.
        load_word(32'h0000005A);
        spi_frame(1'b1, 1'b0, 2'b00, 32'h000000C3, 99, 1'b0, m);
        check("resend_first_no_underrun", urun_pend, 0);
        spi_frame(1'b1, 1'b0, 2'b00, 32'h00000011, 99, 1'b0, m2);
        check("resend_first_word", m, 32'h0000005A);
        check("resend_second_word", m2, 32'h0000005A);
        check("resend_underrun_seen", urun_pend, 0);

        // Daisy-chain bypass while deselected.
        bus.daisy_chain = 1'b1;
        wait_clks(8);
        for (int i = 0; i < 8; i++) begin
            bus.MOSI = 1'($urandom);
            #1;
            check("daisy_miso", bus.MISO, bus.MOSI);
            check("daisy_oe", bus.miso_oe, 1);
            wait_clks(1);
        end
        bus.daisy_chain = 1'b0;
        wait_clks(SYNC + 2);
        check("nodaisy_oe", bus.miso_oe, 0);

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            r_cpol = 1'($urandom);
            r_cpha = 1'($urandom);
            r_len  = 2'($urandom);
            r_nb   = 8 * (int'(r_len) + 1);
            r_stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, r_nb - 1)) : 99;
            bus.daisy_chain = 1'($urandom);
            bus.default_val = 1'($urandom);
            if ($urandom_range(0, 3) != 0) load_word($urandom);
            if ($urandom_range(0, 3) == 0) load_word($urandom);
            spi_frame(r_cpol, r_cpha, r_len, $urandom, r_stop, 1'b0, m);
        end

        // Reset mid-frame in mode 1, 24 bits; CS held low across release.
        bus.daisy_chain = 1'b0;
        bus.default_val = 1'b0;
        wait_clks(8);
        load_word(32'h00C0FFEE);
        spi_frame(1'b0, 1'b1, 2'b10, 32'h00654321, 10, 1'b1, m);
        wait_clks(3);
        rst = 1'b1;
        wait_clks(20);
        check("release_cs_low_not_frame", bus.busy, 0);
        bus.CS = 1'b1;
        wait_clks(10);
        load_word(32'h00ABCDEF);
        spi_frame(1'b0, 1'b1, 2'b10, 32'h00135791, 99, 1'b0, m);
        check("post_reset_master_word", m, 32'h00ABCDEF);
        check("post_reset_rx_data", bus.rx_data, 32'h00135791);

        wait_clks(20);
        check("end_rx_queue_empty", rx_q.size(), 0);
        check("end_err_pending", err_pend, 0);
        check("end_underrun_pending", urun_pend, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth on SCLK/CS/MOSI (min 2).
REQ-002 clk  in  1  system clock; single clock domain.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 SCLK  in  1  SPI clock from master, asynchronous to clk.
REQ-005 CS  in  1  chip select, active-low, asynchronous.
REQ-006 MOSI  in  1  serial data from master.
REQ-007 MISO  out  1  serial data to master.
REQ-008 miso_oe  out  1  MISO drive enable for pad tristate.
REQ-009 CPOL, CPHA, daisy_chain, default_val  in  1 each  mode, chain bypass, idle/fill bit.
REQ-010 transaction_length  in  2  00 8b, 01 16b, 10 24b, 11 32b.
REQ-011 tx_data  in  32, tx_load  in  1, tx_ready  out  1  transmit staging handshake.
REQ-012 rx_data  out  32, rx_valid  out  1  received word, 1-cycle strobe.
REQ-013 busy  out  1, frame_err  out  1, tx_underrun  out  1  status; err/underrun are 1-cycle pulses.

Function
REQ-014 SCLK, CS, MOSI pass through SYNC_STAGES flops; all logic uses synchronized copies (SCLK_s, CS_s, MOSI_s).
REQ-015 Supported SCLK frequency: at most clk/8; faster is unsupported.
REQ-016 States: IDLE, LOAD, ACTIVE, DONE; busy = state != IDLE.
REQ-017 IDLE->LOAD on CS_s high-to-low edge; LOAD->ACTIVE next cycle unconditionally.
REQ-018 LOAD: latch CPOL, CPHA, transaction_length; N = 8*(length+1); bit counter = N; tx_shift <= staging; rx_shift <= 0.
REQ-019 Define k = SCLK_s ^ CPOL ^ CPHA; rising k = sample edge, falling k = shift edge.
REQ-020 ACTIVE sample edge: rx_shift <= {rx_shift[30:0], MOSI_s}; counter decrements.
REQ-021 ACTIVE shift edge: tx_shift <= {tx_shift[30:0], default_val}; when CPHA=1 the first shift edge of the frame does not shift.
REQ-022 MISO while CS_s low = tx_shift[N-1]; miso_oe = 1.
REQ-023 Counter reaching 0: ACTIVE->DONE; rx_data <= rx_shift zero-extended to N bits, rx_valid = 1 for exactly one cycle.
REQ-024 DONE: further SCLK edges ignored; MISO = default_val; DONE->IDLE on CS_s high.
REQ-025 CS_s rising in ACTIVE with counter > 0: abort to IDLE, frame_err pulse, no rx_valid, rx_data unchanged.
REQ-026 CS_s high: miso_oe = daisy_chain; MISO = daisy_chain ? MOSI (unsynchronized pass-through) : default_val.
REQ-027 tx_load while tx_ready=1: staging <= tx_data, tx_ready <= 0 next cycle; tx_load while tx_ready=0 ignored.
REQ-028 LOAD sets tx_ready <= 1; if staging not refreshed since previous LOAD, tx_underrun pulses and previous staging is resent.
REQ-029 tx_load in same cycle as LOAD: LOAD consumes old staging; new data is captured and tx_ready stays 0.
REQ-030 Mode inputs changed mid-frame have no effect until next LOAD.

Reset
REQ-031 rst low asynchronously forces: state IDLE, synchronizers to CS=1 and SCLK=0/MOSI=0, rx_data 0, rx_valid 0, frame_err 0, tx_underrun 0, tx_ready 1, staging 0, shifts 0, counter 0.
REQ-032 Reset during ACTIVE discards the frame with no rx_valid or frame_err.
REQ-033 After release, a frame starts only on a subsequent CS_s falling edge; CS already low at release is not a frame.

Structure
REQ-034 Shared package spi_pkg holds state encodings, length codes, and N decode (8/16/24/32).
REQ-035 One sub-module, spi_sync: parameterized multi-flop synchronizer with async active-low reset and reset value input, instantiated for SCLK, CS, MOSI.

Verification
REQ-036 Mode 0, 8b, tx_data 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data 0x0000003C; one rx_valid pulse.
REQ-037 Mode 3, 32b, tx 0xDEADBEEF, master sends 0x12345678 -> master gets 0xDEADBEEF; rx_data 0x12345678.
REQ-038 CS raised after 5 of 16 bits -> frame_err 1 cycle; rx_valid 0; rx_data unchanged.
REQ-039 Two frames with one tx_load -> second frame resends same word; tx_underrun pulses at second LOAD.
REQ-040 CS high, daisy_chain=1 -> MISO follows MOSI, miso_oe 1; daisy_chain=0 -> miso_oe 0.
REQ-041 rst low mid-frame (mode 1, 24b) -> outputs at reset values immediately; next full frame received correctly.
